dbuf_write_fifo: RTL
====================

// Module: dbuf_write_fifo
// PURPOSE
//  Sits directly downstream of the GTIA pixel output. Takes one pixel write per Fphi0 cycle
//  (dBuf_data/dBuf_addr/dBuf_writeEn) and buffers it in a small FIFO. Forwards each write to
//  the display-buffer memory port over a valid/ready handshake, so memory stalls do not lose
//  pixels until the FIFO fills. Reports dropped pixels and signals when a frame has fully
//  drained after vblank.
// PARAMETERS
//  DATA_W   32  pixel word width (GTIA packs {8'd0, RGB})
//  ADDR_W   16  display-buffer address width
//  DEPTH    16  FIFO entries; power of 2, >= 2
//  PTR_W     4  log2(DEPTH)
// PORTS
//  Fphi0         in   1           system clock; all state updates on posedge
//  rst_b         in   1           asynchronous reset, active-low
//  dBuf_data     in   DATA_W      pixel word from GTIA
//  dBuf_addr     in   ADDR_W      pixel address from GTIA
//  dBuf_writeEn  in   1           push request, one pixel per cycle while high
//  vblank        in   1           GTIA vblank flag; a rising edge marks end of frame
//  mem_data      out  DATA_W      head-of-FIFO pixel word
//  mem_addr      out  ADDR_W      head-of-FIFO address
//  mem_valid     out  1           head entry is valid
//  mem_ready     in   1           memory accepts the head this cycle
//  full          out  1           level == DEPTH
//  empty         out  1           level == 0
//  level         out  PTR_W+1     stored entries, 0..DEPTH
//  overflow_cnt  out  8           pixels dropped this frame; saturates at 8'hFF
//  frame_done    out  1           1-cycle pulse: end-of-frame seen and FIFO drained
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst_b=0), immediate:
//    - pointers 0, level 0, empty=1, full=0, mem_valid=0, overflow_cnt=0, frame_done=0.
//    - FSM to IDLE; vblank edge register cleared. Storage contents are don't-care.
//    - Reset mid-transfer discards all stored pixels.
//  Storage: register array. mem_data/mem_addr are driven combinationally from entry rd_ptr.
//    mem_valid = !empty. Outputs are don't-care when mem_valid=0.
//  Push: occurs when dBuf_writeEn && !full (full sampled before the edge).
//    Writes entry wr_ptr; wr_ptr increments mod DEPTH.
//  Pop: occurs when mem_valid && mem_ready. rd_ptr increments mod DEPTH.
//  Latency: a push into an empty FIFO is visible on mem_valid/mem_data the next cycle.
//    Order is strictly FIFO.
//  Level update: push only +1; pop only -1; push and pop together leaves level unchanged.
//  Full: dBuf_writeEn while full drops the pixel, even if a pop occurs that same cycle.
//    A drop does not disturb stored data. overflow_cnt increments by 1, saturating at 255.
//  Empty: mem_valid=0, so mem_ready is ignored. A push in the same cycle is accepted.
//  Stability: while mem_valid && !mem_ready, mem_data/mem_addr/mem_valid hold unchanged.
//  End-of-frame FSM:
//    - vblank registered as vb_q; eof = vblank && !vb_q.
//    - IDLE : eof -> DRAIN.
//    - DRAIN: next-state level==0 -> DONE; further eof edges are ignored.
//      Pushes during DRAIN are accepted and extend the drain.
//    - DONE : frame_done=1 for exactly this cycle -> IDLE.
//    - eof and level already 0 gives IDLE->DRAIN->DONE: frame_done 2 cycles after the edge.
//  overflow_cnt clear: in DONE it loads 0. If a drop occurs in the DONE cycle, it loads 1.
// TESTING
//  1. Reset with random inputs -> all outputs at reset values.
//     Push A0..A3 with mem_ready=1 -> mem_valid rises 1 cycle after the first push; A0..A3 emerge in order.
//  2. mem_ready=0, push 16 pixels -> full=1, level=16.
//     Push 3 more -> overflow_cnt=3, data unchanged. Then ready=1 -> 16 originals emerge in order.
//  3. Full and a same-cycle pop+push -> push dropped, level=15, overflow_cnt+1.
//     Empty and same-cycle push with ready=1 -> level=1, no pop.
//  4. mem_ready toggled 0/1 pseudo-randomly, 1000 pixels streamed -> scoreboard exact, outputs stable while stalled.
//  5. 5 entries queued, ready=0, vblank rises -> no frame_done until ready=1.
//     frame_done pulses 1 cycle in the cycle after level reaches 0; overflow_cnt then clears.
//  6. rst_b low for 1 cycle mid-stream with level=7 -> level=0, mem_valid=0 immediately.
//     Next push is output first.

Source files
------------

// File: rtl/dbuf_write_fifo.sv
// dbuf_write_fifo: buffers GTIA pixel writes and forwards them to display memory over valid/ready
module dbuf_write_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              Fphi0,
    input  logic              rst_b,
    input  logic [DATA_W-1:0] dBuf_data,
    input  logic [ADDR_W-1:0] dBuf_addr,
    input  logic              dBuf_writeEn,
    input  logic              vblank,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    level,
    output logic [7:0]        overflow_cnt,
    output logic              frame_done
);
    localparam int LW = PTR_W + 1;
    localparam int EW = ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    logic [EW-1:0]    store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic [7:0]       ovf_q;
    logic             vb_q, frame_done_q;
    state_t           state_q;
    logic             push, pop, drop, eof;

    assign full         = level_q == LW'(DEPTH);
    assign empty        = level_q == '0;
    assign mem_valid    = !empty;
    assign level        = level_q;
    assign overflow_cnt = ovf_q;
    assign frame_done   = frame_done_q;
    assign {mem_addr, mem_data} = store_q[rd_ptr_q];

    // Handshake decode; a drop is judged on pre-edge fullness, so a same-cycle pop cannot rescue it
    always_comb begin
        push    = dBuf_writeEn && !full;
        drop    = dBuf_writeEn && full;
        pop     = mem_valid && mem_ready;
        eof     = vblank && !vb_q;
        level_d = (push && !pop) ? level_q + LW'(1) : (!push && pop) ? level_q - LW'(1) : level_q;
    end

    // Pixel storage; contents need no reset since validity is tracked by level
    always_ff @(posedge Fphi0) begin
        if (push) store_q[wr_ptr_q] <= {dBuf_addr, dBuf_data};
    end

    // Pointers and occupancy
    always_ff @(posedge Fphi0 or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // Dropped-pixel counter: saturating, restarted when a frame completes
    always_ff @(posedge Fphi0 or negedge rst_b) begin
        if (!rst_b) ovf_q <= '0;
        else if (state_q == DONE) ovf_q <= drop ? 8'd1 : 8'd0;
        else if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
    end

    // End-of-frame tracker: wait for vblank rise, then for the FIFO to drain, then pulse
    always_ff @(posedge Fphi0 or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            vb_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            vb_q <= vblank;
            case (state_q)
                IDLE: if (eof) state_q <= DRAIN;
                DRAIN: if (level_d == '0) begin
                    state_q      <= DONE;
                    frame_done_q <= 1'b1;
                end
                DONE: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
